// File: rtl/issue_rat_freelist_redeem_arb.sv
// Two-lane redeem arbiter: per-lane FIFOs of freed PRFs, round-robin merged onto the
// free list's single redeem port. Arbitration result is held while the port stalls.
module issue_rat_freelist_redeem_arb #(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] i_redeem0_prf,
  input  logic       i_redeem0_valid,
  output logic       o_redeem0_ready,
  input  logic [5:0] i_redeem1_prf,
  input  logic       i_redeem1_valid,
  output logic       o_redeem1_ready,
  output logic [5:0] o_redeemed_prf,
  output logic       o_redeemed_valid,
  input  logic       i_redeemed_ready
);

  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

  logic [5:0]    mem_q   [2][QUEUE_DEPTH];
  logic [AW-1:0] wptr_q  [2];
  logic [AW-1:0] wptr_d  [2];
  logic [AW-1:0] rptr_q  [2];
  logic [AW-1:0] rptr_d  [2];
  logic [CW-1:0] count_q [2];
  logic [CW-1:0] count_d [2];
  logic          prio_q, prio_d;
  logic          lock_q, lock_d;
  logic          lockLane_q, lockLane_d;

  logic [1:0]    laneValid, laneReady, nonEmpty, enq, deq;
  logic          winner, outValid, handshake;

  always_comb begin
    laneValid = {i_redeem1_valid, i_redeem0_valid};
    for (int n = 0; n < 2; n++) begin
      nonEmpty[n]  = (count_q[n] != '0);
      laneReady[n] = ~reset & (count_q[n] != FULL_CNT);
      enq[n]       = laneValid[n] & laneReady[n];
    end

    // A stalled offer keeps its lane even if the other lane becomes favoured.
    if (lock_q)
      winner = lockLane_q;
    else if (&nonEmpty)
      winner = prio_q;
    else
      winner = ~nonEmpty[0];

    outValid  = ~reset & (|nonEmpty);
    handshake = outValid & i_redeemed_ready;
    deq       = {winner & handshake, ~winner & handshake};

    for (int n = 0; n < 2; n++) begin
      wptr_d[n]  = wptr_q[n] + AW'(enq[n]);
      rptr_d[n]  = rptr_q[n] + AW'(deq[n]);
      count_d[n] = count_q[n] + CW'(enq[n]) - CW'(deq[n]);
    end

    prio_d     = prio_q;
    lock_d     = lock_q;
    lockLane_d = lockLane_q;
    if (handshake) begin
      prio_d = ~winner;
      lock_d = 1'b0;
    end else if (outValid) begin
      lock_d     = 1'b1;
      lockLane_d = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        wptr_q[n]  <= '0;
        rptr_q[n]  <= '0;
        count_q[n] <= '0;
      end
      prio_q     <= 1'b0;
      lock_q     <= 1'b0;
      lockLane_q <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        wptr_q[n]  <= wptr_d[n];
        rptr_q[n]  <= rptr_d[n];
        count_q[n] <= count_d[n];
      end
      prio_q     <= prio_d;
      lock_q     <= lock_d;
      lockLane_q <= lockLane_d;
    end
  end

  // Storage needs no reset; enq is already gated off by reset through the readies.
  always_ff @(posedge clk) begin
    if (enq[0]) mem_q[0][wptr_q[0]] <= i_redeem0_prf;
    if (enq[1]) mem_q[1][wptr_q[1]] <= i_redeem1_prf;
  end

  assign o_redeem0_ready  = laneReady[0];
  assign o_redeem1_ready  = laneReady[1];
  assign o_redeemed_valid = outValid;
  assign o_redeemed_prf   = outValid ? mem_q[winner][rptr_q[winner]] : 6'd0;

endmodule

// File: tb/tb_issue_rat_freelist_redeem_arb.sv
// Self-checking bench for issue_rat_freelist_redeem_arb: a directed vector table
// followed by hand-written wrap-around and mid-operation reset sequences.
module tb_issue_rat_freelist_redeem_arb;

  logic       clk;
  logic       reset;
  logic [5:0] redeem0Prf, redeem1Prf;
  logic       redeem0Valid, redeem1Valid;
  logic       redeem0Ready, redeem1Ready;
  logic [5:0] redeemedPrf;
  logic       redeemedValid;
  logic       redeemedReady;

  int checkCount;
  int passCount;

  typedef struct packed {
    logic       rst;
    logic       v0;
    logic [5:0] p0;
    logic       v1;
    logic [5:0] p1;
    logic       rdy;
    logic       expR0;
    logic       expR1;
    logic       expValid;
    logic [5:0] expPrf;
  } vec_t;

  vec_t vecs[$];

  issue_rat_freelist_redeem_arb #(.QUEUE_DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_redeem0_prf    (redeem0Prf),
    .i_redeem0_valid  (redeem0Valid),
    .o_redeem0_ready  (redeem0Ready),
    .i_redeem1_prf    (redeem1Prf),
    .i_redeem1_valid  (redeem1Valid),
    .o_redeem1_ready  (redeem1Ready),
    .o_redeemed_prf   (redeemedPrf),
    .o_redeemed_valid (redeemedValid),
    .i_redeemed_ready (redeemedReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge so the rising edge sees them settled.
  task automatic applyStimulus(input logic rst, input logic v0, input logic [5:0] p0,
                               input logic v1, input logic [5:0] p1, input logic rdy);
    @(negedge clk);
    reset         = rst;
    redeem0Valid  = v0;
    redeem0Prf    = p0;
    redeem1Valid  = v1;
    redeem1Prf    = p1;
    redeemedReady = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic er0, input logic er1,
                             input logic ev, input logic [5:0] ep);
    checkCount++;
    if ({redeem0Ready, redeem1Ready, redeemedValid, redeemedPrf} === {er0, er1, ev, ep})
      passCount++;
    else
      $display("[TB] FAIL %s: got r0=%b r1=%b valid=%b prf=%0d, want r0=%b r1=%b valid=%b prf=%0d",
               name, redeem0Ready, redeem1Ready, redeemedValid, redeemedPrf, er0, er1, ev, ep);
  endtask

  function automatic void addVec(logic rst, logic v0, logic [5:0] p0, logic v1, logic [5:0] p1,
                                 logic rdy, logic er0, logic er1, logic ev, logic [5:0] ep);
    vec_t v;
    v = '{rst, v0, p0, v1, p1, rdy, er0, er1, ev, ep};
    vecs.push_back(v);
  endfunction

  initial begin
    checkCount    = 0;
    passCount     = 0;
    reset         = 1'b1;
    redeem0Valid  = 1'b0;
    redeem1Valid  = 1'b0;
    redeem0Prf    = 6'd0;
    redeem1Prf    = 6'd0;
    redeemedReady = 1'b0;

    // Reset held with valids high, then a single lane-0 PRF
    addVec(1, 1, 6'd1,  1, 6'd2,  1,  0, 0, 0, 6'd0);
    addVec(1, 1, 6'd1,  1, 6'd2,  1,  0, 0, 0, 6'd0);
    addVec(0, 1, 6'd5,  0, 6'd0,  0,  1, 1, 0, 6'd0);
    addVec(0, 0, 6'd0,  0, 6'd0,  1,  1, 1, 1, 6'd5);
    // Alternation from a fresh reset
    addVec(1, 0, 6'd0,  0, 6'd0,  1,  0, 0, 0, 6'd0);
    addVec(0, 1, 6'd10, 1, 6'd20, 1,  1, 1, 0, 6'd0);
    addVec(0, 1, 6'd11, 1, 6'd21, 1,  1, 1, 1, 6'd10);
    addVec(0, 1, 6'd12, 1, 6'd22, 1,  1, 1, 1, 6'd20);
    addVec(0, 0, 6'd0,  0, 6'd0,  1,  1, 1, 1, 6'd11);
    addVec(0, 0, 6'd0,  0, 6'd0,  1,  1, 1, 1, 6'd21);
    addVec(0, 0, 6'd0,  0, 6'd0,  1,  1, 1, 1, 6'd12);
    addVec(0, 0, 6'd0,  0, 6'd0,  1,  1, 1, 1, 6'd22);
    addVec(0, 0, 6'd0,  0, 6'd0,  1,  1, 1, 0, 6'd0);
    // Stall hold: lane 1 offered while prio favours lane 0, lane 0 fills during stall
    addVec(0, 0, 6'd0,  1, 6'd33, 0,  1, 1, 0, 6'd0);
    addVec(0, 1, 6'd7,  0, 6'd0,  0,  1, 1, 1, 6'd33);
    addVec(0, 0, 6'd0,  0, 6'd0,  0,  1, 1, 1, 6'd33);
    addVec(0, 0, 6'd0,  0, 6'd0,  0,  1, 1, 1, 6'd33);
    addVec(0, 0, 6'd0,  0, 6'd0,  1,  1, 1, 1, 6'd33);
    addVec(0, 0, 6'd0,  0, 6'd0,  1,  1, 1, 1, 6'd7);
    addVec(0, 0, 6'd0,  0, 6'd0,  1,  1, 1, 0, 6'd0);
    // Full lane 1: fifth offer refused, ready returns one cycle after first dequeue
    addVec(0, 0, 6'd0,  1, 6'd40, 0,  1, 1, 0, 6'd0);
    addVec(0, 0, 6'd0,  1, 6'd41, 0,  1, 1, 1, 6'd40);
    addVec(0, 0, 6'd0,  1, 6'd42, 0,  1, 1, 1, 6'd40);
    addVec(0, 0, 6'd0,  1, 6'd43, 0,  1, 1, 1, 6'd40);
    addVec(0, 0, 6'd0,  1, 6'd44, 0,  1, 0, 1, 6'd40);
    addVec(0, 0, 6'd0,  1, 6'd44, 0,  1, 0, 1, 6'd40);
    addVec(0, 0, 6'd0,  0, 6'd0,  1,  1, 0, 1, 6'd40);
    addVec(0, 0, 6'd0,  0, 6'd0,  1,  1, 1, 1, 6'd41);
    addVec(0, 0, 6'd0,  0, 6'd0,  1,  1, 1, 1, 6'd42);
    addVec(0, 0, 6'd0,  0, 6'd0,  1,  1, 1, 1, 6'd43);
    addVec(0, 0, 6'd0,  0, 6'd0,  1,  1, 1, 0, 6'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].v0, vecs[i].p0, vecs[i].v1, vecs[i].p1, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].expR0, vecs[i].expR1,
                  vecs[i].expValid, vecs[i].expPrf);
    end

    // Wrap-around: simultaneous push/pop every cycle, each output is the previous push
    for (int lane = 0; lane < 2; lane++) begin
      logic [5:0] base;
      base = (lane == 0) ? 6'd1 : 6'd50;
      for (int k = 0; k < 10; k++) begin
        if (lane == 0)
          applyStimulus(0, 1, base + 6'(k), 0, 6'd0, 1);
        else
          applyStimulus(0, 0, 6'd0, 1, base + 6'(k), 1);
        checkOutput($sformatf("wrap%0d_%0d", lane, k), 1, 1, k != 0,
                    (k != 0) ? base + 6'(k - 1) : 6'd0);
      end
      applyStimulus(0, 0, 6'd0, 0, 6'd0, 1);
      checkOutput($sformatf("wrapLast%0d", lane), 1, 1, 1, base + 6'd9);
      applyStimulus(0, 0, 6'd0, 0, 6'd0, 1);
      checkOutput($sformatf("wrapEmpty%0d", lane), 1, 1, 0, 6'd0);
    end

    // Mid-operation reset discards three buffered entries per lane
    applyStimulus(0, 1, 6'd11, 1, 6'd21, 0);
    checkOutput("midFill0", 1, 1, 0, 6'd0);
    applyStimulus(0, 1, 6'd12, 1, 6'd22, 0);
    checkOutput("midFill1", 1, 1, 1, 6'd11);
    applyStimulus(0, 1, 6'd13, 1, 6'd23, 0);
    checkOutput("midFill2", 1, 1, 1, 6'd11);
    applyStimulus(1, 0, 6'd0, 0, 6'd0, 0);
    checkOutput("midReset", 0, 0, 0, 6'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 6'd0, 0, 6'd0, 1);
      checkOutput($sformatf("postReset%0d", k), 1, 1, 0, 6'd0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/issue_rat_freelist_redeem_arb.md
# issue_rat_freelist_redeem_arb

Two-lane redeem arbiter placed in front of the PRF free list's single redeem port. It accepts freed physical-register numbers from two independent commit/retire lanes, buffers each lane in its own small FIFO, and forwards them one per cycle to the free list using round-robin arbitration. This decouples dual-retire bursts from the single-entry redeem handshake without dropping or duplicating any PRF.

## Interface
- QUEUE_DEPTH, 4, entries per lane FIFO; power of two, minimum 2
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- i_redeem0_prf  in  6  PRF freed by retire lane 0
- i_redeem0_valid  in  1  lane 0 offers a PRF
- o_redeem0_ready  out  1  lane 0 FIFO can accept this cycle
- i_redeem1_prf  in  6  PRF freed by retire lane 1
- i_redeem1_valid  in  1  lane 1 offers a PRF
- o_redeem1_ready  out  1  lane 1 FIFO can accept this cycle
- o_redeemed_prf  out  6  PRF forwarded to the free list redeem port
- o_redeemed_valid  out  1  forwarded PRF valid
- i_redeemed_ready  in  1  free list accepts the forwarded PRF

## Operation
- Per lane: circular FIFO of QUEUE_DEPTH × 6 bits, read/write pointers of log2(QUEUE_DEPTH) bits wrapping modulo depth, occupancy counter of log2(QUEUE_DEPTH)+1 bits.
- Enqueue lane n when i_redeemn_valid & o_redeemn_ready; write at wptr, wptr+1.
- o_redeemn_ready = ~reset & (countn != QUEUE_DEPTH); registered state only, no dependency on i_redeemed_ready (a full lane stays not-ready even in a cycle it dequeues).
- Arbitration: candidates are non-empty lanes. One priority bit prio (0 = lane 0 favoured). Single candidate wins outright; both non-empty -> lane prio wins.
- o_redeemed_valid = ~reset & (count0 != 0 | count1 != 0); o_redeemed_prf = head entry of winning lane; 6'd0 when not valid.
- Dequeue winner when o_redeemed_valid & i_redeemed_ready; rptr+1, count−1. On dequeue, prio <= ~winner (granted lane drops to lowest priority). prio unchanged when no handshake.
- Simultaneous enqueue and dequeue on one lane: count unchanged, both pointers advance.
- Both lanes enqueue in the same cycle: both accepted independently.
- No bypass: an enqueued PRF is never forwarded in its enqueue cycle.
- Output stability: while o_redeemed_valid & ~i_redeemed_ready, winner and o_redeemed_prf hold (heads and prio do not change; a newly non-empty lane may only change the winner if the current winner was… n/a, since winner lane's head is non-empty it remains a candidate; the other lane becoming non-empty can flip the winner only if prio favours it — prohibited: arbitration result is latched while stalled, see Timing).
- PRF values are not checked or filtered; 6'd0 forwarded like any other value.

## Timing
- Reset (reset high at a rising edge): all counts, pointers cleared, prio <= 0. While reset is high: o_redeem0_ready = o_redeem1_ready = 0, o_redeemed_valid = 0, o_redeemed_prf = 0. Reset mid-operation discards all buffered PRFs.
- First cycle after reset release: both readies 1, o_redeemed_valid 0.
- Latency: PRF enqueued at edge N appears on o_redeemed_prf in cycle N+1 at earliest.
- Throughput: one forwarded PRF per cycle while i_redeemed_ready high; one accepted PRF per lane per cycle.
- Stall hold: register a lock bit plus locked lane when valid & ~ready; while locked, winner = locked lane, cleared on handshake or reset. Valid never deasserts without a handshake.
- o_redeemed_valid/prf are combinational from registered state plus lock; i_redeemed_ready affects only the next state.

## Test plan
- Reset: hold reset 2 cycles with both valids high -> readies 0, o_redeemed_valid 0; after release lane 0 enqueue 6'd5 -> next cycle o_redeemed_prf 5, valid 1.
- Alternation: lane 0 pushes 10,11,12, lane 1 pushes 20,21,22 in the same cycles, ready held 1 -> output order 10,20,11,21,12,22, one per cycle.
- Full: ready 0, lane 1 pushes 4 PRFs -> o_redeem1_ready 0 after 4th; 5th valid not accepted; raise ready -> exactly 4 PRFs out in order, ready returns 1 the cycle after first dequeue.
- Stall hold: lane 1 head 33 offered (prio favours lane 0, lane 0 empty), ready 0 for 3 cycles while lane 0 enqueues 7 -> 33 stays on output; ready 1 -> 33 then 7.
- Wrap-around: 10 sequential push/pop pairs per lane with depth 4 -> no loss, order preserved, counts return to 0.
- Mid-operation reset: lanes hold 3 entries each, assert reset 1 cycle -> valid 0 thereafter, no stale PRF emitted.
